rv32_alu_sequencer: RTL and testbench
=====================================

// Module: rv32_alu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the RV32I R-type/I-type ALU datapath. Fetches each instruction over a
//  valid/ready imem port, decodes rs1/rs2/rd/funct3/funct7/imm, and sequences the register-file reads,
//  the external ALU and the register-file writeback. Also owns the PC. Supported opcodes: 0110011 (OP)
//  and 0010011 (OP-IMM); any other opcode traps.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  PC_STEP   4              PC increment per retired instruction
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  run_en          in   1   1 = fetch and execute; 0 = park in IDLE at an instruction boundary
//  imem_req_valid  out  1   fetch request valid
//  imem_req_addr   out  32  fetch address (= pc)
//  imem_req_ready  in   1   fetch request accepted
//  imem_rsp_valid  in   1   instruction word valid
//  imem_rsp_data   in   32  instruction word
//  rs1_addr        out  5   regfile read port 1 address (instr[19:15])
//  rs2_addr        out  5   regfile read port 2 address (instr[24:20])
//  rs1_data        in   32  regfile read data 1 (asynchronous read)
//  rs2_data        in   32  regfile read data 2 (asynchronous read)
//  alu_op          out  4   {op_mod, funct3}
//  alu_a           out  32  ALU operand A
//  alu_b           out  32  ALU operand B
//  alu_result      in   32  ALU result (combinational)
//  rf_we           out  1   regfile write enable, 1-cycle pulse
//  rf_waddr        out  5   regfile write address (rd)
//  rf_wdata        out  32  regfile write data
//  pc              out  32  current PC
//  retired         out  1   1-cycle pulse per completed instruction
//  illegal         out  1   sticky trap flag
// BEHAVIOUR
//  States: IDLE, FREQ, FWAIT, DECODE, EXEC, WB, TRAP.
//  Reset: state=IDLE, pc=RESET_PC. All other outputs and internal registers are 0.
//  IDLE -> FREQ when run_en=1.
//  FREQ: imem_req_valid=1 and is held until imem_req_ready=1 (no drop, address stable). Then -> FWAIT.
//  FWAIT: instr <= imem_rsp_data when imem_rsp_valid=1, then -> DECODE.
//   imem_rsp_valid is ignored in every other state.
//  DECODE: rs1_addr/rs2_addr driven from the latched instr from DECODE through WB.
//   Captures opA <= rs1_data.
//   opB <= rs2_data (OP) or sign-extended instr[31:20] (OP-IMM).
//   Legality check:
//    - Illegal: opcode other than 0110011/0010011.
//    - OP illegal: funct7 not in {0000000, 0100000}; funct7=0100000 with funct3 not in {000, 101}.
//    - OP-IMM illegal: funct3=001 with imm[11:5]!=0; funct3=101 with imm[11:5] not in {0000000, 0100000}.
//   Illegal -> TRAP; legal -> EXEC.
//  op_mod: OP = funct7[5]; OP-IMM = instr[30] only when funct3=101 (SRAI), otherwise 0 (ADDI never subtracts).
//  EXEC: alu_a=opA, alu_b=opB, alu_op valid for exactly this cycle; result <= alu_result. -> WB.
//   alu_a/alu_b/alu_op hold their values outside EXEC; the ALU result is sampled only in EXEC.
//  WB: rf_waddr=instr[11:7], rf_wdata=result, rf_we=1 unless rd==0.
//   retired=1 and pc <= pc+PC_STEP (32-bit wrap) for every legal instruction, including rd=0.
//   Then -> FREQ if run_en=1, else IDLE.
//  run_en=0 mid-instruction: the current instruction completes; run_en is sampled only in IDLE and WB.
//  TRAP: illegal=1 (sticky). pc holds the faulting address. No rf_we, no retired, no imem requests.
//   Exit only by reset.
//  Latency: zero-wait imem gives 5 cycles/instruction (FREQ, FWAIT, DECODE, EXEC, WB).
//   Each imem stall cycle adds 1.
//  Reset mid-operation: immediate return to reset values. No partial writeback (rf_we deasserts asynchronously).
// TESTING
//  T1 reset: rst_n=0 -> all outputs 0, pc=RESET_PC. run_en=0 after release -> stays IDLE, imem_req_valid=0.
//  T2 ADD x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7, adder model
//   -> alu_op=4'b0000; WB: rf_we=1, rf_waddr=3, rf_wdata=12, retired=1, pc 0->4; 5 cycles total.
//  T3 SUB (0x402081B3) -> alu_op=4'b1000. ADDI x1,x0,-1 (0xFFF00093) -> alu_b=0xFFFFFFFF, alu_op=4'b0000.
//   SRAI x1,x1,3 (0x4030D093) -> alu_op=4'b1101, alu_b=0x00000403.
//  T4 ADD x0,x1,x2 (0x00208033) -> rf_we=0 in WB, retired=1, pc+=4.
//  T5 JAL (0x0000006F) at pc=8 -> TRAP, illegal=1, pc=8. No further imem_req_valid over 20 cycles.
//   Same result for funct7=0000001 (MUL, 0x022081B3).
//  T6 backpressure: imem_req_ready low 3 cycles, rsp delayed 2 -> req_valid/addr stable, 10 cycles/instruction.
//   rst_n pulsed during EXEC -> no rf_we, pc=RESET_PC.

Source files
------------

// File: rtl/rv32_alu_sequencer.sv
// Multi-cycle control FSM for the RV32I OP/OP-IMM ALU datapath.
// Fetches over a valid/ready imem port, decodes, sequences regfile reads, ALU and writeback.
module rv32_alu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_en,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic        retired,
    output logic        illegal
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;

    typedef enum logic [2:0] {
        StIdle, StFreq, StFwait, StDecode, StExec, StWb, StTrap
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        is_op, is_op_imm;
    logic        legal;
    logic        op_mod;
    logic        in_decode_window;
    logic        in_wb;

    assign opcode    = instr_q[6:0];
    assign rd        = instr_q[11:7];
    assign funct3    = instr_q[14:12];
    assign funct7    = instr_q[31:25];
    assign imm       = {{20{instr_q[31]}}, instr_q[31:20]};
    assign is_op     = (opcode == OpcOp);
    assign is_op_imm = (opcode == OpcOpImm);

    always_comb begin
        legal  = 1'b0;
        op_mod = 1'b0;
        if (is_op) begin
            op_mod = funct7[5];
            if (funct7 == 7'b0000000) begin
                legal = 1'b1;
            end else if (funct7 == 7'b0100000) begin
                legal = (funct3 == 3'b000) || (funct3 == 3'b101);
            end
        end else if (is_op_imm) begin
            // Only SRAI uses instr[30]; ADDI with a negative immediate must not subtract.
            op_mod = (funct3 == 3'b101) ? instr_q[30] : 1'b0;
            if (funct3 == 3'b001) begin
                legal = (funct7 == 7'b0000000);
            end else if (funct3 == 3'b101) begin
                legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            end else begin
                legal = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        op_d      = op_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            StIdle: begin
                if (run_en) state_d = StFreq;
            end
            StFreq: begin
                if (imem_req_ready) state_d = StFwait;
            end
            StFwait: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                opa_d = rs1_data;
                opb_d = is_op ? rs2_data : imm;
                op_d  = {op_mod, funct3};
                if (legal) begin
                    state_d = StExec;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end
            end
            StExec: begin
                result_d = alu_result;
                state_d  = StWb;
            end
            StWb: begin
                pc_d    = pc_q + PC_STEP;
                state_d = run_en ? StFreq : StIdle;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_decode_window = (state_q == StDecode) || (state_q == StExec) || (state_q == StWb);
    assign in_wb            = (state_q == StWb);

    // Writeback strobes decode straight from state so reset drops them asynchronously.
    assign imem_req_valid = (state_q == StFreq);
    assign imem_req_addr  = pc_q;
    assign rs1_addr       = in_decode_window ? instr_q[19:15] : 5'd0;
    assign rs2_addr       = in_decode_window ? instr_q[24:20] : 5'd0;
    assign alu_a          = opa_q;
    assign alu_b          = opb_q;
    assign alu_op         = op_q;
    assign rf_we          = in_wb && (rd != 5'd0);
    assign rf_waddr       = in_wb ? rd : 5'd0;
    assign rf_wdata       = in_wb ? result_q : 32'd0;
    assign pc             = pc_q;
    assign retired        = in_wb;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_rv32_alu_sequencer.sv
// Directed bench for rv32_alu_sequencer: imem driver, fixed regfile data, small ALU model.
module tb_rv32_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run_en;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        retired;
    logic        illegal;

    int errors;
    int checks;

    int          obs_cycles;
    logic        obs_retired;
    logic        obs_stable;
    logic        obs_we;
    logic [4:0]  obs_waddr;
    logic [31:0] obs_wdata;
    logic [31:0] obs_pc;
    logic [4:0]  obs_rs1;
    logic [4:0]  obs_rs2;

    rv32_alu_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run_en         (run_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .alu_op         (alu_op),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_result     (alu_result),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .pc             (pc),
        .retired        (retired),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = alu_a + alu_b;
        case (alu_op)
            4'b1000: alu_result = alu_a - alu_b;
            4'b1101: alu_result = $signed(alu_a) >>> alu_b[4:0];
            default: alu_result = alu_a + alu_b;
        endcase
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        run_en         = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one fetch/execute from the current negedge; returns at the WB negedge (or after a bound).
    task automatic run_instr(input logic [31:0] word, input int req_stall, input int rsp_stall);
        int n;
        logic [31:0] addr0;
        obs_cycles  = 0;
        obs_retired = 1'b0;
        obs_stable  = 1'b1;
        obs_we      = 1'b0;
        n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req_valid !== 1'b1) return;
        addr0      = imem_req_addr;
        obs_cycles = 1;
        for (int i = 0; i < req_stall; i++) begin
            @(negedge clk);
            obs_cycles++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== addr0) obs_stable = 1'b0;
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        obs_cycles++;
        for (int i = 0; i < rsp_stall; i++) begin
            @(negedge clk);
            obs_cycles++;
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        obs_cycles++;
        n = 0;
        while (retired !== 1'b1 && n < 6) begin
            @(negedge clk);
            obs_cycles++;
            n++;
        end
        if (retired === 1'b1) begin
            obs_retired = 1'b1;
            obs_we      = rf_we;
            obs_waddr   = rf_waddr;
            obs_wdata   = rf_wdata;
            obs_pc      = pc;
            obs_rs1     = rs1_addr;
            obs_rs2     = rs2_addr;
        end
    endtask

    task automatic test_reset();
        logic seen_req;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, imem_req_addr, rs1_addr, rs2_addr, alu_op, alu_a, alu_b,
             rf_we, rf_waddr, rf_wdata, retired, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs req=%b we=%b ret=%b ill=%b op=%h",
                     imem_req_valid, rf_we, retired, illegal, alu_op);
        end
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", pc, 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        seen_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (imem_req_valid !== 1'b0) seen_req = 1'b1;
        end
        checks++;
        if (seen_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got req_valid=%b expected 0", seen_req);
        end
    endtask

    task automatic test_add();
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        run_en   = 1'b1;
        run_instr(32'h002081B3, 0, 0);
        run_en = 1'b0;
        checks++;
        if (obs_cycles !== 5 || obs_retired !== 1'b1) begin
            errors++;
            $display("FAIL add_latency: got %0d cycles retired=%b expected 5 retired=1",
                     obs_cycles, obs_retired);
        end
        checks++;
        if ({obs_we, obs_waddr, obs_wdata} !== {1'b1, 5'd3, 32'd12}) begin
            errors++;
            $display("FAIL add_wb: got we=%b rd=%0d data=%h expected we=1 rd=3 data=0000000c",
                     obs_we, obs_waddr, obs_wdata);
        end
        checks++;
        if ({obs_rs1, obs_rs2, alu_op} !== {5'd1, 5'd2, 4'b0000}) begin
            errors++;
            $display("FAIL add_decode: got rs1=%0d rs2=%0d op=%b expected rs1=1 rs2=2 op=0000",
                     obs_rs1, obs_rs2, alu_op);
        end
        @(negedge clk);
        checks++;
        if (obs_pc !== 32'h0 || pc !== 32'h4) begin
            errors++;
            $display("FAIL add_pc: got wb_pc=%h pc=%h expected 00000000 then 00000004",
                     obs_pc, pc);
        end
    endtask

    task automatic test_rd_zero();
        run_en = 1'b1;
        run_instr(32'h00208033, 0, 0);
        run_en = 1'b0;
        checks++;
        if ({obs_retired, obs_we} !== 2'b10) begin
            errors++;
            $display("FAIL rd0_wb: got retired=%b we=%b expected retired=1 we=0",
                     obs_retired, obs_we);
        end
        @(negedge clk);
        checks++;
        if (pc !== 32'h8) begin
            errors++;
            $display("FAIL rd0_pc: got %h expected %h", pc, 32'h8);
        end
    endtask

    task automatic test_trap(input logic [31:0] word, input logic [31:0] exp_pc);
        logic bad;
        run_en = 1'b1;
        run_instr(word, 0, 0);
        checks++;
        if (obs_retired !== 1'b0 || illegal !== 1'b1 || pc !== exp_pc) begin
            errors++;
            $display("FAIL trap_state %h: got retired=%b illegal=%b pc=%h expected 0 1 %h",
                     word, obs_retired, illegal, pc, exp_pc);
        end
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req_valid !== 1'b0 || rf_we !== 1'b0 || retired !== 1'b0 ||
                illegal !== 1'b1 || pc !== exp_pc) bad = 1'b1;
        end
        run_en = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL trap_sticky %h: got activity=%b expected 0", word, bad);
        end
    endtask

    task automatic test_back_to_back();
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        run_en   = 1'b1;
        run_instr(32'h402081B3, 0, 0);
        checks++;
        if (obs_cycles !== 5 || alu_op !== 4'b1000 || obs_wdata !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL sub: got cycles=%0d op=%b data=%h expected 5 1000 fffffffe",
                     obs_cycles, alu_op, obs_wdata);
        end
        run_instr(32'hFFF00093, 0, 0);
        checks++;
        if (obs_cycles !== 5 || alu_op !== 4'b0000 || alu_b !== 32'hFFFF_FFFF ||
            obs_waddr !== 5'd1 || obs_wdata !== 32'd4) begin
            errors++;
            $display("FAIL addi: got cycles=%0d op=%b b=%h rd=%0d data=%h expected 5 0000 ffffffff 1 4",
                     obs_cycles, alu_op, alu_b, obs_waddr, obs_wdata);
        end
        rs1_data = 32'h8000_0000;
        run_instr(32'h4030D093, 0, 0);
        run_en = 1'b0;
        checks++;
        if (obs_cycles !== 5 || alu_op !== 4'b1101 || alu_b !== 32'h0000_0403 ||
            obs_wdata !== 32'hF000_0000 || obs_pc !== 32'h8) begin
            errors++;
            $display("FAIL srai: got cycles=%0d op=%b b=%h data=%h pc=%h expected 5 1101 00000403 f0000000 8",
                     obs_cycles, alu_op, alu_b, obs_wdata, obs_pc);
        end
        @(negedge clk);
        checks++;
        if (pc !== 32'hC) begin
            errors++;
            $display("FAIL b2b_pc: got %h expected %h", pc, 32'hC);
        end
    endtask

    task automatic test_backpressure();
        int   n;
        logic bad;
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        run_en   = 1'b1;
        run_instr(32'h002081B3, 3, 2);
        checks++;
        if (obs_cycles !== 10 || obs_stable !== 1'b1 || obs_retired !== 1'b1) begin
            errors++;
            $display("FAIL backpressure: got cycles=%0d stable=%b retired=%b expected 10 1 1",
                     obs_cycles, obs_stable, obs_retired);
        end
        // Second instruction: reset lands while it sits in EXEC.
        n = 0;
        @(negedge clk);
        while (imem_req_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h002081B3;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 32'h4 || retired !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_exec: got pc=%h retired=%b expected 00000004 0", pc, retired);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || pc !== 32'h0 || retired !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_exec: got we=%b pc=%h retired=%b expected 0 00000000 0",
                     rf_we, pc, retired);
        end
        bad = 1'b0;
        run_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rf_we !== 1'b0 || retired !== 1'b0) bad = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rf_we !== 1'b0 || retired !== 1'b0 || imem_req_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL no_partial_wb: got activity=%b expected 0", bad);
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst_n          = 1'b1;
        run_en         = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        rs1_data       = 32'd0;
        rs2_data       = 32'd0;

        test_reset();
        test_add();
        test_rd_zero();
        test_trap(32'h0000006F, 32'h8);
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_backpressure();
        apply_reset();
        test_trap(32'h022081B3, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
